dmem_responder: RTL

- Data-memory responder serving the pipeline's M-stage memory port.
- The datapath drives the address (ALU result), write data, size and strobe. This block returns the read word, a completion pulse and a stall request to the hazard unit.
- Adds configurable wait states, byte/half/word writes and misalignment detection, replacing the zero-latency memory model.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_bank.sv | 31 +++
 rtl/dmem_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - access size encodings (byte/half/word; 2'b11 behaves as word)
//   - responder state enum
//   - helpers: misalignment test, byte-lane mask, lane-replicated store data
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // Half needs an even address; word (and 2'b11) needs a 4-byte aligned one.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      if (size[1])
         misaligned = (off != 2'b00);
      else if (size == SZ_HALF)
         misaligned = off[0];
      else
         misaligned = 1'b0;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: lane_mask = 4'b0001 << off;
         SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   // Store data arrives right-aligned; replicating it across the word puts
   // the right bytes under whichever lanes the mask enables.
   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SZ_BYTE: lane_data = {4{data[7:0]}};
         SZ_HALF: lane_data = {2{data[15:0]}};
         default: lane_data = data;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: single-port 2**ADDR_W x 32 storage with per-byte write enables
// and a registered read port. No reset; contents survive responder reset.
//   clk   in   clock
//   en    in   port enable (read when we == 0, write otherwise)
//   we    in   byte-lane write enables
//   addr  in   word index
//   wdata in   write word (lanes selected by we)
//   rdata out  registered read word; holds until the next enabled read
module dmem_bank #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
         if (we == 4'b0000) rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data-memory responder with configurable wait states.
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   memenM     in   request strobe (held while stalled)
//   memwriteM  in   1 = store, 0 = load
//   sizeM      in   00 byte, 01 half, 10/11 word
//   addrM      in   byte address
//   writedataM in   right-aligned store data
//   readdataM  out  aligned read word, held until the next read ack
//   ackM       out  one-cycle completion pulse
//   memstallM  out  stall request to the hazard unit
//   adelM      out  misaligned-load pulse
//   adesM      out  misaligned-store pulse
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memenM,
   input  logic        memwriteM,
   input  logic [1:0]  sizeM,
   input  logic [31:0] addrM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        ackM,
   output logic        memstallM,
   output logic        adelM,
   output logic        adesM
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t            state, state_nx;
   logic [3:0]        cnt, cnt_nx;
   logic              mis, accept;
   logic [ADDR_W-1:0] req_idx;

   logic [ADDR_W-1:0] idx_p1;
   logic [3:0]        mask_p1;
   logic [31:0]       data_p1;
   logic              wr_p1;

   logic              rd_vld;
   logic              bank_en, rd_go;
   logic [3:0]        bank_we;
   logic [ADDR_W-1:0] bank_addr;
   logic [31:0]       bank_rdata;

   // Address bits above the word index alias onto the same storage.
   logic              unused_addr_hi;
   assign unused_addr_hi = ^addrM[31:ADDR_W+2];

   assign req_idx = addrM[ADDR_W+1:2];
   assign mis     = misaligned(sizeM, addrM[1:0]);
   assign accept  = (state == IDLE) && memenM && !mis;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               cnt_nx   = CNT_INIT;
               state_nx = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            cnt_nx = cnt - 4'd1;
            if (cnt <= 4'd1) state_nx = RESP;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         rd_vld <= 1'b0;
         adelM  <= 1'b0;
         adesM  <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         if (rd_go) rd_vld <= 1'b1;
         adelM  <= (state == IDLE) && memenM && mis && !memwriteM;
         adesM  <= (state == IDLE) && memenM && mis &&  memwriteM;
      end
   end

   // --- capture stage: request fields frozen at acceptance ---
   always_ff @(posedge clk) begin
      if (accept) begin
         idx_p1  <= req_idx;
         mask_p1 <= lane_mask(sizeM, addrM[1:0]);
         data_p1 <= lane_data(sizeM, writedataM);
         wr_p1   <= memwriteM;
      end
   end

   // The bank read is launched on the edge entering RESP so the word is on
   // the port during the ack cycle. With LATENCY=1 that edge is the
   // acceptance edge itself, so address and write flag come straight from
   // the inputs. The write commits on the RESP-exit edge, which always
   // precedes the next acceptance, so a following read sees it.
   assign rd_go     = (state_nx == RESP) &&
                      !((state == IDLE) ? memwriteM : wr_p1);
   assign bank_we   = ((state == RESP) && wr_p1) ? mask_p1 : 4'b0000;
   assign bank_en   = rd_go || (bank_we != 4'b0000);
   assign bank_addr = (state == IDLE) ? req_idx : idx_p1;

   dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk   (clk),
      .en    (bank_en),
      .we    (bank_we),
      .addr  (bank_addr),
      .wdata (data_p1),
      .rdata (bank_rdata)
   );

   assign readdataM = rd_vld ? bank_rdata : 32'h0000_0000;
   assign ackM      = (state == RESP);
   assign memstallM = rst && memenM && !mis && ((state == IDLE) || (state == BUSY));

endmodule
